// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver
// Assembles one byte from an idle-high, LSB-first serial line framed by a
// start bit (0) and a stop bit (1). Bits are sampled mid-bit using a fixed
// clocks-per-bit divider. A good frame loads data_out and pulses data_valid;
// a bad stop bit pulses frame_err and leaves data_out untouched.
module serial_byte_receiver #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    // Mid-bit offset and cycle counter width (at least one bit).
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    // START samples on the H-th edge after the falling edge was seen.
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    // DATA/STOP sample once every CLKS_PER_BIT edges.
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    // Next-state, counters, shift register and output pulses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!sin) begin
                    state_d = S_START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (sin) begin
                        // Line went back high before mid-bit: false start.
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = CNT_ZERO;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    // LSB-first: each new bit enters at the top and moves down.
                    shift_d = {sin, shift_q[7:1]};
                    cnt_d   = CNT_ZERO;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    if (sin) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                bit_d   = 3'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= CNT_ZERO;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Self-checking bench for serial_byte_receiver with CLKS_PER_BIT = 4.
// Inputs change on the falling clock edge; outputs are sampled on the
// falling edge, so "k" below is the index of the rising edge just taken,
// counted from t0 (the first edge that sees the start bit).
module tb_serial_byte_receiver;

    localparam int C   = 4;
    localparam int DEC = C / 2 + 9 * C;   // stop-bit decision edge (38)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Per-frame observations.
    int v_cnt, e_cnt, both_cnt, v_k, e_k, v_cyc, busy0, busy_dec;

    logic [7:0] exp_data;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t tbl[6];

    serial_byte_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one full frame (start, 8 data LSB-first, stop), 10*C edges.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        int k;
        bits = {stop, b, 1'b0};
        v_cnt = 0; e_cnt = 0; both_cnt = 0; v_k = -1; e_k = -1;
        v_cyc = -1; busy0 = -1; busy_dec = -1;
        for (int j = 0; j < 10; j++) begin
            sin = bits[j];
            for (int m = 0; m < C; m++) begin
                @(posedge clk);
                @(negedge clk);
                k = j * C + m;
                if (data_valid) begin v_cnt++; v_k = k; v_cyc = cyc; end
                if (frame_err) begin e_cnt++; e_k = k; end
                if (data_valid && frame_err) both_cnt++;
                if (k == 0) busy0 = int'(busy);
                if (k == DEC) busy_dec = int'(busy);
            end
        end
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Compare one frame's observations against the expected outcome.
    task automatic check_frame(input string tag, input logic [7:0] ed,
                               input int ev, input int ee);
        check({tag, " valid_count"}, v_cnt, ev);
        check({tag, " err_count"}, e_cnt, ee);
        check({tag, " data_out"}, int'(data_out), int'(ed));
        check({tag, " both_high"}, both_cnt, 0);
        check({tag, " busy_at_t0"}, busy0, 1);
        check({tag, " busy_after_decision"}, busy_dec, 0);
        if (ev == 1) check({tag, " valid_edge"}, v_k, DEC);
        else         check({tag, " err_edge"}, e_k, DEC);
    endtask

    initial begin
        int c1, c2, pulses;
        logic [7:0] rb;
        logic       rs;

        tbl[0] = '{8'hA5, 1'b1, 2, 8'hA5, 1, 0};
        tbl[1] = '{8'h3C, 1'b0, 3, 8'hA5, 0, 1};
        tbl[2] = '{8'h01, 1'b1, 0, 8'h01, 1, 0};
        tbl[3] = '{8'hFF, 1'b1, 2, 8'hFF, 1, 0};
        tbl[4] = '{8'h00, 1'b1, 1, 8'h00, 1, 0};
        tbl[5] = '{8'h80, 1'b0, 3, 8'h00, 0, 1};

        // Reset held with the line toggling: everything stays at zero.
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sin = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            check("reset_outputs", int'({data_out, data_valid, frame_err, busy}), 0);
        end
        @(negedge clk);
        sin = 1'b1;
        rst = 1'b1;
        idle(3);
        exp_data = 8'h00;

        // Table-driven frames.
        for (int t = 0; t < 6; t++) begin
            send_frame(tbl[t].data, tbl[t].stop);
            check_frame($sformatf("tbl%0d", t), tbl[t].exp_data,
                        tbl[t].exp_valid, tbl[t].exp_err);
            exp_data = tbl[t].exp_data;
            idle(tbl[t].gap);
        end

        // Back-to-back 0x01 then 0xFF: pulses exactly one frame apart.
        send_frame(8'h01, 1'b1);
        c1 = v_cyc;
        check("b2b_first_data", int'(data_out), 32'h01);
        send_frame(8'hFF, 1'b1);
        c2 = v_cyc;
        check("b2b_second_data", int'(data_out), 32'hFF);
        check("b2b_spacing", c2 - c1, 10 * C);
        exp_data = 8'hFF;
        idle(2);

        // Glitch: one low cycle is a false start, resolved at t0+H.
        pulses = 0;
        sin = 1'b0;
        @(posedge clk); @(negedge clk);
        check("glitch_busy_t0", int'(busy), 1);
        sin = 1'b1;
        @(posedge clk); @(negedge clk);
        check("glitch_busy_t1", int'(busy), 1);
        @(posedge clk); @(negedge clk);
        check("glitch_busy_t2", int'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (data_valid || frame_err || busy) pulses++;
        end
        check("glitch_quiet", pulses, 0);
        check("glitch_data_kept", int'(data_out), int'(exp_data));

        // Reset in the middle of data bit 4 of 0x77.
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h77, 1'b0};
            for (int j = 0; j < 5; j++) begin
                sin = bits[j];
                repeat (C) begin @(posedge clk); @(negedge clk); end
            end
            sin = bits[5];
            repeat (2) begin @(posedge clk); @(negedge clk); end
            check("midreset_busy_before", int'(busy), 1);
            rst = 1'b0;
            #1;
            check("midreset_busy_now", int'(busy), 0);
            check("midreset_pulses", int'({data_valid, frame_err}), 0);
            check("midreset_data", int'(data_out), 0);
            repeat (3) begin @(posedge clk); @(negedge clk); end
            rst = 1'b1;
            exp_data = 8'h00;
        end
        idle(3);
        send_frame(8'h55, 1'b1);
        check_frame("after_reset", 8'h55, 1, 0);
        exp_data = 8'h55;
        idle(2);

        // Random frames against the frame-level reference model.
        for (int r = 0; r < 24; r++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs);
            if (rs) exp_data = rb;
            check_frame($sformatf("rand%0d", r), exp_data, rs ? 1 : 0, rs ? 0 : 1);
            if (rs) idle($urandom_range(0, 2));
            else    idle(3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Framed serial-to-parallel receiver that assembles one byte from a single-wire, LSB-first bit stream: idle-high line, start bit 0, eight data bits, stop bit 1. It is the stage directly upstream of the 8-bit parallel register. `data_out` drives the register's `D` input, and `data_valid` is the one-cycle load qualifier. Bit timing is derived from `clk` by a fixed clocks-per-bit divider with mid-bit sampling.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal values ≥ 2. `H = CLKS_PER_BIT/2` (integer division) is the mid-bit offset.
- `clk`  input  1  rising-edge clock. All state changes on this edge.
- `rst`  input  1  asynchronous, active-low reset. `rst=0` forces reset immediately; release is sampled on `clk`.
- `sin`  input  1  serial line, idle high. Already synchronous to `clk`.
- `data_out`  output  8  last correctly framed byte. Holds its value between frames.
- `data_valid`  output  1  one-cycle pulse. `data_out` was updated with a good frame.
- `frame_err`  output  1  one-cycle pulse. Stop bit sampled 0; frame discarded.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values: FSM = IDLE, bit counter 0, cycle counter 0, shift register 0x00, `data_out` 0x00, `data_valid` 0, `frame_err` 0, `busy` 0.
- **IDLE**
  - Edge with `sin=0`: go to START, clear cycle counter. That edge is t0.
  - `sin=1`: stay in IDLE.
- **START**
  - Count cycles. At edge t0+H, sample `sin`.
  - `sin=1`: false start. Return to IDLE with no output pulse.
  - `sin=0`: go to DATA, clear cycle counter and bit index.
- **DATA**
  - Sample `sin` once every `CLKS_PER_BIT` cycles. Bit i (i=0..7) is sampled at edge t0+H+(i+1)·CLKS_PER_BIT.
  - Each sample shifts the shift register right, with `sin` inserted at bit 7. After 8 samples, bit 0 holds the first data bit (LSB-first).
  - After bit 7: go to STOP, clear cycle counter.
- **STOP**
  - Sample `sin` at edge t0+H+9·CLKS_PER_BIT.
  - `sin=1`: `data_out` ← shift register; `data_valid`=1 for exactly one cycle.
  - `sin=0`: `frame_err`=1 for exactly one cycle; `data_out` unchanged.
  - Either way, return to IDLE on the same edge.
- Break (line held low): IDLE sees `sin=0` on the next edge and immediately starts a new frame.
- `data_valid` and `frame_err` are never high together.
- `busy` is decoded from the registered state: 1 in START, DATA and STOP.
- Reset mid-frame: the frame is aborted and no pulse is produced. The next frame after release is received normally.
- Cycle counter width is `$clog2(CLKS_PER_BIT)` bits, minimum 1, with no wrap beyond `CLKS_PER_BIT-1`. Bit index is 3 bits.

## Timing
- Latency: good-frame outputs are visible after edge t0+H+9·CLKS_PER_BIT.
  - With `CLKS_PER_BIT`=4 this is t0+38.
- Pulses are registered: high for the one cycle following the deciding edge, low from the next edge.
- Back-to-back frames: after the STOP decision the FSM is in IDLE. A next start bit that begins at the nominal end of the stop bit is detected, with no lost frames.
- `busy`:
  - Rises after t0.
  - Falls after the STOP decision edge, or after t0+H on a false start.
  - Drops immediately (asynchronously) when `rst`=0.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, each bit held 4 cycles.
- Reset: `rst`=0 with `sin` toggling → `data_out`=0x00, `data_valid`=0, `frame_err`=0, `busy`=0 throughout.
- Good frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) → single `data_valid` pulse after edge t0+38, `data_out`=0xA5, `frame_err`=0, `busy` low afterwards.
- Glitch: `sin`=0 for one cycle only at t0, then 1 → `sin` sampled 1 at t0+2, FSM back to IDLE, `busy` low after t0+2, no pulses, `data_out` unchanged.
- Bad stop: frame 0x3C with stop bit 0 → `frame_err` pulse after t0+38, no `data_valid`, `data_out` keeps previous value 0xA5.
- Back-to-back 0x01 then 0xFF with no idle gap → two `data_valid` pulses exactly 40 cycles apart, `data_out`=0x01 then 0xFF.
- Reset mid-frame: `rst`=0 during data bit 4 of 0x77 → `busy`=0 immediately, no pulse; after release, frame 0x55 → `data_valid`, `data_out`=0x55.
